// File: rtl/alu_seq_pkg.sv
// Shared op encodings and FSM state type for the sequential ALU.
package alu_seq_pkg;

    localparam logic [1:0] ARITH = 2'b00;
    localparam logic [1:0] LOGIC = 2'b01;
    localparam logic [1:0] SHR   = 2'b10;
    localparam logic [1:0] SHL   = 2'b11;

    localparam logic [1:0] LOG_AND = 2'b00;
    localparam logic [1:0] LOG_OR  = 2'b01;
    localparam logic [1:0] LOG_XOR = 2'b10;
    localparam logic [1:0] LOG_NOT = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_arith_logic.sv
// Combinational WIDTH-bit arithmetic/logic unit; shift groups yield zero here
// because shifts are executed iteratively by the parent.
module alu_arith_logic
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [3:0]       sel_i,
    output logic [WIDTH-1:0] f_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   sum;

    always_comb begin
        case (sel_i[1:0])
            2'b00:   y = '0;
            2'b01:   y = b_i;
            2'b10:   y = ~b_i;
            default: y = '1;
        endcase
    end

    assign sum = {1'b0, a_i} + {1'b0, y} + {{WIDTH{1'b0}}, cin_i};

    always_comb begin
        f_o    = '0;
        cout_o = 1'b0;
        ovf_o  = 1'b0;
        case (sel_i[3:2])
            ARITH: begin
                f_o    = sum[WIDTH-1:0];
                cout_o = sum[WIDTH];
                // Operands of equal sign producing a result of the other sign
                ovf_o  = (a_i[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            LOGIC: begin
                case (sel_i[1:0])
                    LOG_AND: f_o = a_i & b_i;
                    LOG_OR:  f_o = a_i | b_i;
                    LOG_XOR: f_o = a_i ^ b_i;
                    default: f_o = ~a_i;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes; shifts run one bit per cycle
// through an accumulator, everything else completes in the accept cycle.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [3:0]       sel_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] f_o,
    output logic             cout_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             ovf_o
);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q, f_q;
    logic [SHW-1:0]   cnt_q;
    logic             left_q, cout_q, zero_q, neg_q, ovf_q;

    logic [WIDTH-1:0] alu_f, f_d, acc_d;
    logic             alu_cout, alu_ovf, cout_d, ovf_d, step_bit;
    logic             accept, is_shift;
    logic [SHW-1:0]   k;

    alu_arith_logic #(.WIDTH(WIDTH)) u_alu (
        .a_i    (a_i),
        .b_i    (b_i),
        .cin_i  (cin_i),
        .sel_i  (sel_i),
        .f_o    (alu_f),
        .cout_o (alu_cout),
        .ovf_o  (alu_ovf)
    );

    assign in_ready_o = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign is_shift   = (sel_i[3:2] == SHR) || (sel_i[3:2] == SHL);
    assign k          = b_i[SHW-1:0];

    // Single-cycle result: a zero-distance shift simply passes A through
    always_comb begin
        f_d    = is_shift ? a_i : alu_f;
        cout_d = is_shift ? 1'b0 : alu_cout;
        ovf_d  = is_shift ? 1'b0 : alu_ovf;
    end

    always_comb begin
        acc_d    = left_q ? {acc_q[WIDTH-2:0], 1'b0} : {1'b0, acc_q[WIDTH-1:1]};
        step_bit = left_q ? acc_q[WIDTH-1] : acc_q[0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            f_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == SHIFT) begin
            acc_q  <= acc_d;
            cout_q <= step_bit;
            cnt_q  <= cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
                state_q <= DONE;
                f_q     <= acc_d;
                zero_q  <= (acc_d == '0);
                neg_q   <= acc_d[WIDTH-1];
                ovf_q   <= 1'b0;
            end
        end else if (accept) begin
            if (is_shift && (k != '0)) begin
                state_q <= SHIFT;
                acc_q   <= a_i;
                cnt_q   <= k;
                left_q  <= (sel_i[3:2] == SHL);
            end else begin
                state_q <= DONE;
                f_q     <= f_d;
                cout_q  <= cout_d;
                zero_q  <= (f_d == '0);
                neg_q   <= f_d[WIDTH-1];
                ovf_q   <= ovf_d;
            end
        end else if ((state_q == DONE) && out_ready_i) begin
            state_q <= IDLE;
        end
    end

    assign out_valid_o = (state_q == DONE);
    assign f_o         = f_q;
    assign cout_o      = cout_q;
    assign zero_o      = zero_q;
    assign neg_o       = neg_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against a plain-arithmetic model.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, cin, out_valid, out_ready;
    logic [W-1:0] a, b, f;
    logic [3:0]   sel;
    logic         cout, zero, neg, ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [W-1:0] f;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
        int           lat;
    } exp_t;

    alu_seq #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .sel_i       (sel),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .f_o         (f),
        .cout_o      (cout),
        .zero_o      (zero),
        .neg_o       (neg),
        .ovf_o       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic exp_t model(input int av, input int bv, input int cv, input logic [3:0] s);
        exp_t e;
        int   y, sum, ssum, k, r;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        e.lat  = 1;
        r      = 0;
        k      = bv % W;
        case (s[3:2])
            2'b00: begin
                case (s[1:0])
                    2'b00:   y = 0;
                    2'b01:   y = bv;
                    2'b10:   y = 255 - bv;
                    default: y = 255;
                endcase
                sum    = av + y + cv;
                r      = sum % 256;
                e.cout = (sum >= 256);
                ssum   = sgn(av) + sgn(y) + cv;
                e.ovf  = (ssum > 127) || (ssum < -128);
            end
            2'b01: begin
                case (s[1:0])
                    2'b00:   r = av & bv;
                    2'b01:   r = av | bv;
                    2'b10:   r = av ^ bv;
                    default: r = 255 - av;
                endcase
            end
            2'b10: begin
                r      = av >> k;
                e.cout = (k > 0) ? ((av >> (k - 1)) & 1) : 0;
                e.lat  = 1 + k;
            end
            default: begin
                r      = (av << k) % 256;
                e.cout = (k > 0) ? ((av >> (W - k)) & 1) : 0;
                e.lat  = 1 + k;
            end
        endcase
        e.f    = W'(r);
        e.zero = (r == 0);
        e.neg  = (r >= 128);
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e);
        check({tag, "_f"},    f,    e.f);
        check({tag, "_cout"}, cout, e.cout);
        check({tag, "_zero"}, zero, e.zero);
        check({tag, "_neg"},  neg,  e.neg);
        check({tag, "_ovf"},  ovf,  e.ovf);
    endtask

    // One full transaction: issue, wait for result, hold under backpressure, retire
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic [3:0] s, input int hold);
        exp_t e;
        int   lat, guard;
        e = model(av, bv, cv, s);
        @(negedge clk);
        a = av; b = bv; cin = cv; sel = s; in_valid = 1'b1; out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sel = 4'($urandom);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            check("busy_ready", in_ready, 0);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, e.lat);
        check_result("res", e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check_result("hold", e);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("retire", out_valid, 0);
        $display("[TB] sel=%b a=%h b=%h cin=%0d -> f=%h cout=%0d z=%0d n=%0d v=%0d lat=%0d",
                 s, av, bv, cv, f, cout, zero, neg, ovf, lat);
    endtask

    initial begin
        exp_t e1, e2;
        exp_t q[$];
        logic seen;
        logic [3:0] s;
        logic [W-1:0] ra, rb;
        logic rc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sel = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_f",     f, 0);
        check("rst_cout",  cout, 0);
        check("rst_zero",  zero, 0);
        check("rst_neg",   neg, 0);
        check("rst_ovf",   ovf, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;

        do_op(8'h7F, 8'h01, 1'b0, 4'b0001, 0);
        do_op(8'h05, 8'h05, 1'b1, 4'b0010, 0);
        do_op(8'hF0, 8'h00, 1'b0, 4'b0111, 0);
        do_op(8'h81, 8'h01, 1'b0, 4'b1100, 0);
        do_op(8'h81, 8'h03, 1'b0, 4'b1000, 0);
        do_op(8'h81, 8'h07, 1'b0, 4'b1100, 0);
        do_op(8'h81, 8'h08, 1'b0, 4'b1000, 0);

        // Backpressure for 5 cycles, then retire and accept on the same edge
        e1 = model(8'h3C, 8'h55, 0, 4'b0110);
        e2 = model(8'h80, 8'h80, 0, 4'b0001);
        @(negedge clk);
        a = 8'h3C; b = 8'h55; cin = 1'b0; sel = 4'b0110; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_ready", in_ready, 0);
            check_result("bp", e1);
        end
        a = 8'h80; b = 8'h80; cin = 1'b0; sel = 4'b0001; in_valid = 1'b1; out_ready = 1'b1;
        #1 check("b2b_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("b2b_valid", out_valid, 1);
        check_result("b2b", e2);
        $display("[TB] back-to-back f=%h cout=%0d v=%0d", f, cout, ovf);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Streaming burst of single-cycle ops with the sink always ready
        out_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e1 = q.pop_front();
                check("burst_valid", out_valid, 1);
                check_result("burst", e1);
                $display("[TB] burst %0d f=%h", i - 1, f);
            end
            if (i < 20) begin
                ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
                s  = {1'b0, 3'($urandom)};
                q.push_back(model(ra, rb, rc, s));
                a = ra; b = rb; cin = rc; sel = s; in_valid = 1'b1;
                #1 check("burst_ready", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b0;

        for (int i = 0; i < 60; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 4'($urandom), $urandom_range(0, 3));
        end

        // Reset during a long shift discards the in-flight result
        @(negedge clk);
        a = 8'hFF; b = 8'h07; cin = 1'b0; sel = 4'b1000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_f",     f, 0);
        check("mid_rst_cout",  cout, 0);
        check("mid_rst_ready", in_ready, 1);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no_stale", seen, 0);
        $display("[TB] reset mid-shift f=%h valid=%0d", f, out_valid);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
